servo_pwm_array: RTL and testbench
==================================

// Module: servo_pwm_array
// PURPOSE
//  Multi-channel hobby-servo PWM generator with per-channel slew-limited position ramping.
//  Parametrised successor of the single-channel toggle-driven servo driver:
//  - N channels share one frame counter.
//  - Absolute targets arrive over a valid/ready command port; each channel ramps one STEP per frame.
//  - A rotating 16-bit status word reports channel positions.
//  Sits between the control/UART command decoder and the servo header pins; clocked from the 1 MHz tick clock.
// PARAMETERS
//  CHANNELS    4      number of servo outputs (1..16)
//  FRAME_TICKS 20000  mclk cycles per PWM frame (20 ms at 1 MHz)
//  MIN_TICKS   400    pulse width at position 0
//  STEP_TICKS  10     pulse-width increment per position unit
//  POS_MAX     220    highest legal position; max pulse = MIN_TICKS+POS_MAX*STEP_TICKS = 2600
//  CW          15     frame counter width; must hold FRAME_TICKS-1
// PORTS
//  mclk        in   1         1 MHz system clock
//  rst_n       in   1         asynchronous active-low reset
//  cmd_valid   in   1         command present
//  cmd_ready   out  1         command accepted when cmd_valid && cmd_ready
//  cmd_ch      in   4         target channel index
//  cmd_pos     in   8         target position, 0..POS_MAX
//  cmd_en      in   1         1 = enable channel, 0 = disable (output held low)
//  cmd_err     out  1         one-cycle pulse: accepted command had cmd_ch >= CHANNELS (command dropped)
//  servo       out  CHANNELS  PWM outputs, registered
//  at_target   out  CHANNELS  1 when cur_pos == tgt_pos for that channel
//  frame_start out  1         one-cycle pulse on the cycle counter == 0
//  status_out  out  16        {ch[3:0], en, at_target, 2'b00, cur_pos[7:0]} of the reported channel
// BEHAVIOUR
//  Reset (rst_n low, async): counter=0, every cur_pos=0, tgt_pos=0, en=0.
//   Outputs: servo=0, at_target=all 1, frame_start=0, cmd_ready=0, cmd_err=0, status_out=0.
//   Status channel pointer = 0.
//  Frame counter: increments every mclk; on FRAME_TICKS-1 it wraps to 0.
//   frame_start is registered high during the cycle counter==0.
//  PWM: servo[i] <= en[i] && (counter < MIN_TICKS + cur_pos[i]*STEP_TICKS).
//   One-cycle registered latency vs counter.
//   Compare arithmetic at CW bits; the product is computed at CW bits with no truncation.
//  Ramp (frame update), applied when counter==0, all channels in parallel:
//   cur_pos < tgt_pos -> cur_pos+1
//   cur_pos > tgt_pos -> cur_pos-1
//   else hold.
//   Never overshoots; position changes by at most 1 per frame (STEP_TICKS ticks of pulse).
//   The new cur_pos first affects the PWM compare on the cycle after the update.
//  Command handshake:
//   cmd_ready=1 in all cycles after reset except the cycle counter==FRAME_TICKS-1 (snapshot cycle).
//   This guarantees no target write races the ramp update.
//   On accept with cmd_ch < CHANNELS: tgt_pos[ch] <= min(cmd_pos, POS_MAX) and en[ch] <= cmd_en, next cycle.
//   Values > POS_MAX saturate to POS_MAX silently.
//   On accept with cmd_ch >= CHANNELS: no state change; cmd_err=1 for one cycle.
//   Disabling a channel holds servo low from the next compare.
//   cur_pos keeps ramping, so re-enable resumes with no jump.
//   Back-to-back commands are accepted one per cycle; last write to a channel wins.
//  Status: on counter==0, status_out latches the pointed channel's fields using post-update cur_pos.
//   The pointer then advances, wrapping CHANNELS-1 -> 0.
//  at_target: combinational compare of registered cur_pos/tgt_pos.
//  Reset mid-frame: all outputs drop immediately (async).
//   After release, counting restarts at 0 and the first frame is a full FRAME_TICKS long.
// TESTING
//  1. Reset release, no commands, run 2 frames -> servo all 0, frame_start every 20000 cycles,
//     at_target=all 1, cmd_ready=0 only on counter 19999.
//  2. Cmd ch0 pos=5 en=1 -> pulse widths 410,420,430,440,450 ticks in frames 1..5;
//     steady at 450; at_target[0] rises after the 5th update.
//  3. Cmd ch1 pos=250 en=1 -> tgt saturates to 220; after 220 frames pulse=2600, holds.
//     Then cmd pos=218 -> 2590, 2580, hold.
//  4. Cmd ch=7 with CHANNELS=4 -> cmd_err one-cycle pulse; no channel state changes.
//     Hold cmd_valid high across counter 19999 -> accepted on counter 0, not on 19999.
//  5. Ch2 ramping to 100, disable at pos 40 for 10 frames, re-enable -> servo[2] low 10 frames,
//     resumes at pulse 400+50*10=900.
//  6. Assert rst_n low mid-pulse -> servo drops same cycle; status_out cycles ch0,1,2,3,0 on frame starts.

Source files
------------

// File: rtl/servo_pwm_array.sv
// servo_pwm_array
//   Multi-channel hobby-servo PWM generator. All channels share one frame
//   counter. Each channel holds an absolute target position written over a
//   valid/ready command port, and its current position ramps one unit per
//   frame toward that target. A rotating status word reports one channel per
//   frame.
//
// Ports
//   mclk         1 MHz system clock
//   rst_n        asynchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    command port ready (low on the last tick of each frame)
//   cmd_ch       target channel index
//   cmd_pos      target position, saturated to POS_MAX
//   cmd_en       1 = channel enabled, 0 = output held low
//   cmd_err      one-cycle pulse after an accepted command to a missing channel
//   servo        registered PWM outputs, one per channel
//   at_target    per-channel cur_pos == tgt_pos
//   frame_start  high during the cycle the counter is 0
//   status_out   {ch[3:0], en, at_target, 2'b00, cur_pos[7:0]} of one channel
//
// Handshake: a command transfers on every rising edge where cmd_valid and
// cmd_ready are both high; the initiator holds cmd_ch/cmd_pos/cmd_en stable
// while cmd_valid is high and not yet accepted.

module servo_pwm_array #(
   parameter int CHANNELS    = 4,
   parameter int FRAME_TICKS = 20000,
   parameter int MIN_TICKS   = 400,
   parameter int STEP_TICKS  = 10,
   parameter int POS_MAX     = 220,
   parameter int CW          = 15
) (
   input  logic                mclk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [3:0]          cmd_ch,
   input  logic [7:0]          cmd_pos,
   input  logic                cmd_en,
   output logic                cmd_err,
   output logic [CHANNELS-1:0] servo,
   output logic [CHANNELS-1:0] at_target,
   output logic                frame_start,
   output logic [15:0]         status_out
);

   localparam logic [CW-1:0] LAST_TICK = CW'(FRAME_TICKS - 1);
   localparam logic [CW-1:0] MIN_W     = CW'(MIN_TICKS);
   localparam logic [CW-1:0] STEP_W    = CW'(STEP_TICKS);
   localparam logic [7:0]    POS_LIM   = 8'(POS_MAX);
   localparam logic [4:0]    CH_LIM    = 5'(CHANNELS);
   localparam logic [3:0]    PTR_LAST  = 4'(CHANNELS - 1);

   logic [CW-1:0]       counter;
   logic [CW-1:0]       counter_next;
   logic                snapshot;
   logic [7:0]          cur_pos  [CHANNELS];
   logic [7:0]          tgt_pos  [CHANNELS];
   logic [7:0]          next_pos [CHANNELS];
   logic [CW-1:0]       thr      [CHANNELS];
   logic [CHANNELS-1:0] en;
   logic [3:0]          ptr;
   logic                accept;
   logic                ch_ok;
   logic [7:0]          pos_sat;
   logic                sel_en;
   logic [7:0]          sel_next;
   logic [7:0]          sel_tgt;

   // The last tick of a frame is the snapshot cycle: the ramp update and the
   // status latch happen on the edge that ends it, and the command port is
   // closed during it so no target write lands on the same edge.
   assign snapshot     = (counter == LAST_TICK);
   assign counter_next = snapshot ? '0 : counter + CW'(1);

   assign accept  = cmd_valid && cmd_ready;
   assign ch_ok   = ({1'b0, cmd_ch} < CH_LIM);
   assign pos_sat = (cmd_pos > POS_LIM) ? POS_LIM : cmd_pos;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         next_pos[i] = cur_pos[i];
         if (cur_pos[i] < tgt_pos[i]) begin
            next_pos[i] = cur_pos[i] + 8'd1;
         end else if (cur_pos[i] > tgt_pos[i]) begin
            next_pos[i] = cur_pos[i] - 8'd1;
         end
         at_target[i] = (cur_pos[i] == tgt_pos[i]);
         thr[i]       = MIN_W + CW'(cur_pos[i]) * STEP_W;
      end
   end

   // Fields of the channel the status pointer selects, taken from the
   // post-update position so the word reflects the frame about to start.
   always_comb begin
      sel_en   = 1'b0;
      sel_next = 8'd0;
      sel_tgt  = 8'd0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (ptr == 4'(i)) begin
            sel_en   = en[i];
            sel_next = next_pos[i];
            sel_tgt  = tgt_pos[i];
         end
      end
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         counter     <= '0;
         frame_start <= 1'b0;
         cmd_ready   <= 1'b0;
         cmd_err     <= 1'b0;
         status_out  <= 16'd0;
         ptr         <= 4'd0;
         en          <= '0;
         servo       <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cur_pos[i] <= 8'd0;
            tgt_pos[i] <= 8'd0;
         end
      end else begin
         counter     <= counter_next;
         frame_start <= snapshot;
         cmd_ready   <= (counter_next != LAST_TICK);
         cmd_err     <= accept && !ch_ok;

         for (int i = 0; i < CHANNELS; i++) begin
            servo[i] <= en[i] && (counter < thr[i]);
            if (snapshot) begin
               cur_pos[i] <= next_pos[i];
            end
            // Decoding against each in-range index means an out-of-range
            // channel simply matches nothing.
            if (accept && (cmd_ch == 4'(i))) begin
               tgt_pos[i] <= pos_sat;
               en[i]      <= cmd_en;
            end
         end

         if (snapshot) begin
            status_out <= {ptr, sel_en, (sel_next == sel_tgt), 2'b00, sel_next};
            ptr        <= (ptr == PTR_LAST) ? 4'd0 : ptr + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Directed bench for servo_pwm_array with a short frame so every scenario
// (including the full ramp to POS_MAX) fits in a few thousand cycles.
// Frame 64 ticks, pulse = 8 + 2*pos, POS_MAX 20 (max pulse 48).

module tb_servo_pwm_array;

   localparam int CH  = 4;
   localparam int FT  = 64;
   localparam int MT  = 8;
   localparam int ST  = 2;
   localparam int PM  = 20;
   localparam int CWB = 7;

   logic          mclk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [3:0]    cmd_ch = 4'd0;
   logic [7:0]    cmd_pos = 8'd0;
   logic          cmd_en = 1'b0;
   logic          cmd_err;
   logic [CH-1:0] servo;
   logic [CH-1:0] at_target;
   logic          frame_start;
   logic [15:0]   status_out;

   int n_checks = 0;
   int n_errors = 0;

   servo_pwm_array #(
      .CHANNELS(CH), .FRAME_TICKS(FT), .MIN_TICKS(MT),
      .STEP_TICKS(ST), .POS_MAX(PM), .CW(CWB)
   ) dut (
      .mclk(mclk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .cmd_en(cmd_en),
      .cmd_err(cmd_err), .servo(servo), .at_target(at_target),
      .frame_start(frame_start), .status_out(status_out)
   );

   // clock / reset
   always #5 mclk = ~mclk;

   // ---------------- driver tasks ----------------
   task automatic wait_frame_start();
      int n;
      n = 0;
      @(negedge mclk);
      while (!frame_start && n < FT + 4) begin
         @(negedge mclk);
         n++;
      end
      if (!frame_start) begin
         n_checks++;
         n_errors++;
         $display("FAIL frame_start_timeout: no frame_start within %0d cycles", FT + 4);
      end
   endtask

   // Counts high samples of servo[c] over one frame starting at frame_start;
   // also returns at_target and status_out seen at that frame start.
   task automatic measure_frame(input int c, output int w,
                                output logic [CH-1:0] at, output logic [15:0] st);
      wait_frame_start();
      at = at_target;
      st = status_out;
      w  = int'(servo[c]);
      for (int i = 1; i < FT; i++) begin
         @(negedge mclk);
         w += int'(servo[c]);
      end
   endtask

   // Called just after a negedge; returns just after the negedge following acceptance.
   task automatic send_cmd(input logic [3:0] ch, input logic [7:0] pos, input logic en);
      int n;
      cmd_ch    = ch;
      cmd_pos   = pos;
      cmd_en    = en;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < FT + 4) begin
         @(negedge mclk);
         n++;
      end
      if (!cmd_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL cmd_accept_timeout: ch=%0d not accepted", ch);
         cmd_valid = 1'b0;
      end else begin
         @(posedge mclk);
         @(negedge mclk);
         cmd_valid = 1'b0;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge mclk);
      n_checks++; if (servo !== 4'b0000) begin n_errors++; $display("FAIL reset_servo: got %b want 0000", servo); end
      n_checks++; if (at_target !== 4'b1111) begin n_errors++; $display("FAIL reset_at_target: got %b want 1111", at_target); end
      n_checks++; if (frame_start !== 1'b0) begin n_errors++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
      n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
      n_checks++; if (cmd_err !== 1'b0) begin n_errors++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
      n_checks++; if (status_out !== 16'h0000) begin n_errors++; $display("FAIL reset_status: got %h want 0000", status_out); end
   endtask

   // Release reset and run two idle frames; tick k is the counter value mod FT.
   task automatic test_idle_frames();
      int fs_bad, rdy_bad, servo_bad, at_bad, fs_seen;
      fs_bad = 0; rdy_bad = 0; servo_bad = 0; at_bad = 0; fs_seen = 0;
      rst_n = 1'b1;
      for (int k = 1; k <= 2 * FT + 2; k++) begin
         @(negedge mclk);
         if (frame_start !== ((k % FT) == 0)) fs_bad++;
         if (frame_start === 1'b1) fs_seen++;
         if (cmd_ready !== ((k % FT) != FT - 1)) rdy_bad++;
         if (servo !== 4'b0000) servo_bad++;
         if (at_target !== 4'b1111) at_bad++;
         if (k == FT) begin
            n_checks++; if (status_out !== 16'h0400) begin n_errors++; $display("FAIL idle_status_f1: got %h want 0400", status_out); end
         end
         if (k == 2 * FT) begin
            n_checks++; if (status_out !== 16'h1400) begin n_errors++; $display("FAIL idle_status_f2: got %h want 1400", status_out); end
         end
      end
      n_checks++; if (fs_bad !== 0) begin n_errors++; $display("FAIL idle_frame_start_timing: %0d bad cycles want 0", fs_bad); end
      n_checks++; if (fs_seen !== 2) begin n_errors++; $display("FAIL idle_frame_start_count: got %0d want 2", fs_seen); end
      n_checks++; if (rdy_bad !== 0) begin n_errors++; $display("FAIL idle_cmd_ready: %0d bad cycles want 0", rdy_bad); end
      n_checks++; if (servo_bad !== 0) begin n_errors++; $display("FAIL idle_servo: %0d high cycles want 0", servo_bad); end
      n_checks++; if (at_bad !== 0) begin n_errors++; $display("FAIL idle_at_target: %0d bad cycles want 0", at_bad); end
   endtask

   task automatic test_ramp_ch0();
      int w, exp_w;
      logic [CH-1:0] at;
      logic [15:0] st;
      send_cmd(4'd0, 8'd5, 1'b1);
      n_checks++; if (cmd_err !== 1'b0) begin n_errors++; $display("FAIL ramp_cmd_err: got %b want 0", cmd_err); end
      for (int f = 1; f <= 7; f++) begin
         measure_frame(0, w, at, st);
         exp_w = MT + ST * ((f < 5) ? f : 5);
         n_checks++; if (w !== exp_w) begin n_errors++; $display("FAIL ramp_width_f%0d: got %0d want %0d", f, w, exp_w); end
         n_checks++; if (at[0] !== (f >= 5)) begin n_errors++; $display("FAIL ramp_at_target_f%0d: got %b want %b", f, at[0], (f >= 5)); end
      end
   endtask

   task automatic test_saturate_ch1();
      int w, exp_w;
      logic [CH-1:0] at;
      logic [15:0] st;
      send_cmd(4'd1, 8'd250, 1'b1);
      for (int f = 1; f <= 22; f++) begin
         measure_frame(1, w, at, st);
         exp_w = MT + ST * ((f < PM) ? f : PM);
         n_checks++; if (w !== exp_w) begin n_errors++; $display("FAIL sat_width_f%0d: got %0d want %0d", f, w, exp_w); end
      end
      n_checks++; if (at[1] !== 1'b1) begin n_errors++; $display("FAIL sat_at_target: got %b want 1", at[1]); end
      send_cmd(4'd1, 8'd18, 1'b1);
      measure_frame(1, w, at, st);
      n_checks++; if (w !== 46) begin n_errors++; $display("FAIL down_width_1: got %0d want 46", w); end
      measure_frame(1, w, at, st);
      n_checks++; if (w !== 44) begin n_errors++; $display("FAIL down_width_2: got %0d want 44", w); end
      measure_frame(1, w, at, st);
      n_checks++; if (w !== 44) begin n_errors++; $display("FAIL down_width_hold: got %0d want 44", w); end
   endtask

   task automatic test_bad_channel();
      int w;
      logic [CH-1:0] at;
      logic [15:0] st;
      send_cmd(4'd7, 8'd9, 1'b1);
      n_checks++; if (cmd_err !== 1'b1) begin n_errors++; $display("FAIL bad_cmd_err_pulse: got %b want 1", cmd_err); end
      @(negedge mclk);
      n_checks++; if (cmd_err !== 1'b0) begin n_errors++; $display("FAIL bad_cmd_err_end: got %b want 0", cmd_err); end
      n_checks++; if (at_target !== 4'b1111) begin n_errors++; $display("FAIL bad_at_target: got %b want 1111", at_target); end
      measure_frame(0, w, at, st);
      n_checks++; if (w !== 18) begin n_errors++; $display("FAIL bad_ch0_width: got %0d want 18", w); end
      measure_frame(1, w, at, st);
      n_checks++; if (w !== 44) begin n_errors++; $display("FAIL bad_ch1_width: got %0d want 44", w); end

      // Command held across the snapshot cycle: refused there, taken at tick 0.
      wait_frame_start();
      repeat (FT - 2) @(negedge mclk);
      n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL hold_ready_pre: got %b want 1", cmd_ready); end
      @(negedge mclk);
      n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL hold_ready_snapshot: got %b want 0", cmd_ready); end
      cmd_ch = 4'd3; cmd_pos = 8'd2; cmd_en = 1'b0; cmd_valid = 1'b1;
      @(negedge mclk);
      n_checks++; if (frame_start !== 1'b1) begin n_errors++; $display("FAIL hold_frame_start: got %b want 1", frame_start); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL hold_ready_tick0: got %b want 1", cmd_ready); end
      n_checks++; if (at_target !== 4'b1111) begin n_errors++; $display("FAIL hold_not_taken: got %b want 1111", at_target); end
      @(posedge mclk);
      @(negedge mclk);
      cmd_valid = 1'b0;
      n_checks++; if (at_target !== 4'b0111) begin n_errors++; $display("FAIL hold_taken: got %b want 0111", at_target); end
      n_checks++; if (servo[3] !== 1'b0) begin n_errors++; $display("FAIL hold_ch3_disabled: got %b want 0", servo[3]); end
   endtask

   task automatic test_disable_resume();
      int w, cnt;
      logic [CH-1:0] at;
      logic [15:0] st;
      send_cmd(4'd2, 8'd20, 1'b1);
      for (int f = 1; f <= 7; f++) begin
         measure_frame(2, w, at, st);
         n_checks++; if (w !== MT + ST * f) begin n_errors++; $display("FAIL dis_ramp_f%0d: got %0d want %0d", f, w, MT + ST * f); end
      end
      wait_frame_start();             // pos 8
      repeat (39) @(negedge mclk);
      send_cmd(4'd2, 8'd20, 1'b0);
      for (int f = 9; f <= 17; f++) begin
         measure_frame(2, w, at, st);
         n_checks++; if (w !== 0) begin n_errors++; $display("FAIL dis_low_pos%0d: got %0d want 0", f, w); end
      end
      wait_frame_start();             // pos 18, still disabled
      cnt = int'(servo[2]);
      for (int i = 1; i < 40; i++) begin
         @(negedge mclk);
         cnt += int'(servo[2]);
      end
      n_checks++; if (cnt !== 0) begin n_errors++; $display("FAIL dis_low_partial: got %0d want 0", cnt); end
      send_cmd(4'd2, 8'd20, 1'b1);
      measure_frame(2, w, at, st);
      n_checks++; if (w !== 46) begin n_errors++; $display("FAIL resume_pos19: got %0d want 46", w); end
      measure_frame(2, w, at, st);
      n_checks++; if (w !== 48) begin n_errors++; $display("FAIL resume_pos20: got %0d want 48", w); end
      measure_frame(2, w, at, st);
      n_checks++; if (w !== 48) begin n_errors++; $display("FAIL resume_hold: got %0d want 48", w); end
   endtask

   task automatic test_reset_mid_pulse();
      int n;
      logic [15:0] exp_st;
      wait_frame_start();
      repeat (5) @(negedge mclk);
      n_checks++; if (servo !== 4'b0111) begin n_errors++; $display("FAIL mid_pulse_servo: got %b want 0111", servo); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (servo !== 4'b0000) begin n_errors++; $display("FAIL mid_reset_servo: got %b want 0000", servo); end
      n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL mid_reset_ready: got %b want 0", cmd_ready); end
      n_checks++; if (status_out !== 16'h0000) begin n_errors++; $display("FAIL mid_reset_status: got %h want 0000", status_out); end
      n_checks++; if (at_target !== 4'b1111) begin n_errors++; $display("FAIL mid_reset_at_target: got %b want 1111", at_target); end
      @(negedge mclk);
      rst_n = 1'b1;
      n = 0;
      @(negedge mclk);
      n++;
      while (!frame_start && n < FT + 4) begin
         @(negedge mclk);
         n++;
      end
      n_checks++; if (n !== FT) begin n_errors++; $display("FAIL first_frame_len: got %0d want %0d", n, FT); end
      n_checks++; if (status_out !== 16'h0400) begin n_errors++; $display("FAIL status_ch0: got %h want 0400", status_out); end
      for (int j = 1; j <= 4; j++) begin
         wait_frame_start();
         exp_st = {4'(j % 4), 12'h400};
         n_checks++; if (status_out !== exp_st) begin n_errors++; $display("FAIL status_rot_%0d: got %h want %h", j, status_out, exp_st); end
      end
   endtask

   initial begin
      test_reset();
      test_idle_frames();
      test_ramp_ch0();
      test_saturate_ch1();
      test_bad_channel();
      test_disable_resume();
      test_reset_mid_pulse();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
